mem_bus_ctrl: RTL and testbench

//  Parametrised successor of the CPU load/store path. Decodes addr[31:24] into N_SLAVES regions,

---
 rtl/mem_bus_ctrl_pkg.sv | 27 ++
 rtl/mem_bus_ctrl_lsu_align.sv | 49 ++++
 rtl/mem_bus_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared encodings for the memory bus controller: access sizes (funct3), abort causes, FSM states.
package mem_bus_ctrl_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ALIGN   = 2'b01;
  localparam logic [1:0] EXC_DECODE  = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_e;

  // Stores ignore size[2], so BU/HU behave as B/H there; the legal code set is the same.
  function automatic logic size_legal(input logic [2:0] size);
    return size inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_lsu_align.sv
// Byte-lane handling for one access: size/alignment legality, store strobes and replication,
// load shift and sign/zero extension. Purely combinational.
module mem_bus_ctrl_lsu_align
  import mem_bus_ctrl_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] rdata_sh;

  assign rdata_sh = rdata >> {addr_lo, 3'b000};

  always_comb begin
    legal     = size_legal(size);
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = rdata_sh;
    case (size)
      SZ_B, SZ_BU: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{rdata_sh[7] & ~size[2]}}, rdata_sh[7:0]};
      end
      SZ_H, SZ_HU: begin
        legal     = legal & ~addr_lo[0];
        wstrb     = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{rdata_sh[15] & ~size[2]}}, rdata_sh[15:0]};
      end
      SZ_W: begin
        legal = legal & (addr_lo == 2'b00);
        wstrb = 4'b1111;
      end
      default: ;
    endcase
    if (!wr) begin
      wstrb = 4'b0000;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU load/store bus controller: decodes addr[31:24] to one of N_SLAVES regions, runs one
// req/ack access at a time with a timeout, and returns aligned load data or an abort cause.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [2:0]            cpu_size,
  input  logic                  cpu_wr,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_exc,
  output logic [1:0]            cpu_cause,
  output logic [N_SLAVES-1:0]   s_sel,
  output logic [31:0]           s_addr,
  output logic                  s_wr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic [32*N_SLAVES-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]   s_ack
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_e                state_q;
  logic [31:0]           addr_q;
  logic [2:0]            size_q;
  logic                  wr_q;
  logic [N_SLAVES-1:0]   s_sel_q;
  logic [31:0]           s_wdata_q;
  logic [3:0]            s_wstrb_q;
  logic [TO_W-1:0]       to_cnt_q;
  logic                  cpu_ready_q;
  logic                  cpu_done_q;
  logic                  cpu_exc_q;
  logic [1:0]            cpu_cause_q;
  logic [31:0]           cpu_rdata_q;

  logic                  idle;
  logic [N_SLAVES-1:0]   sel_dec;
  logic [31:0]           sel_rdata;
  logic                  sel_ack;
  logic                  al_legal;
  logic [3:0]            al_wstrb;
  logic [31:0]           al_wdata;
  logic [31:0]           al_rdata;

  assign idle = (state_q == ST_IDLE);

  // An all-zero decode means the region lies beyond the last slave.
  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_dec
    assign sel_dec[gi] = (cpu_addr[31:24] == 8'(gi));
  end

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (s_sel_q[k]) begin
        sel_rdata = sel_rdata | s_rdata[32*k +: 32];
      end
    end
  end

  assign sel_ack = |(s_ack & s_sel_q);

  // The lane logic sees the live request in IDLE and the captured request afterwards.
  mem_bus_ctrl_lsu_align u_align (
    .addr_lo   (idle ? cpu_addr[1:0] : addr_q[1:0]),
    .size      (idle ? cpu_size : size_q),
    .wr        (idle ? cpu_wr : wr_q),
    .wdata     (cpu_wdata),
    .rdata     (sel_rdata),
    .legal     (al_legal),
    .wstrb     (al_wstrb),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      wr_q        <= 1'b0;
      s_sel_q     <= '0;
      s_wdata_q   <= '0;
      s_wstrb_q   <= '0;
      to_cnt_q    <= '0;
      cpu_ready_q <= 1'b1;
      cpu_done_q  <= 1'b0;
      cpu_exc_q   <= 1'b0;
      cpu_cause_q <= EXC_NONE;
      cpu_rdata_q <= '0;
    end else begin
      cpu_done_q  <= 1'b0;
      cpu_exc_q   <= 1'b0;
      cpu_cause_q <= EXC_NONE;
      cpu_rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            addr_q      <= cpu_addr;
            size_q      <= cpu_size;
            wr_q        <= cpu_wr;
            s_wdata_q   <= al_wdata;
            s_wstrb_q   <= al_wstrb;
            cpu_ready_q <= 1'b0;
            if (!al_legal) begin
              state_q     <= ST_ERR;
              cpu_exc_q   <= 1'b1;
              cpu_cause_q <= EXC_ALIGN;
            end else if (sel_dec == '0) begin
              state_q     <= ST_ERR;
              cpu_exc_q   <= 1'b1;
              cpu_cause_q <= EXC_DECODE;
            end else begin
              state_q <= ST_WAIT;
              s_sel_q <= sel_dec;
            end
          end
        end
        ST_WAIT: begin
          // Ack takes priority over a timeout expiring on the same edge.
          if (sel_ack) begin
            state_q     <= ST_RESP;
            s_sel_q     <= '0;
            to_cnt_q    <= '0;
            cpu_done_q  <= 1'b1;
            cpu_rdata_q <= wr_q ? 32'h0 : al_rdata;
          end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            state_q     <= ST_ERR;
            s_sel_q     <= '0;
            to_cnt_q    <= '0;
            cpu_exc_q   <= 1'b1;
            cpu_cause_q <= EXC_TIMEOUT;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        ST_RESP, ST_ERR: begin
          state_q     <= ST_IDLE;
          cpu_ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_exc   = cpu_exc_q;
  assign cpu_cause = cpu_cause_q;
  assign s_sel     = s_sel_q;
  assign s_addr    = addr_q;
  assign s_wr      = wr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: a per-cycle expectation model built from access rules,
// plus literal checks on captured DUT values for the hand-computed cases.
module tb_mem_bus_ctrl;

  localparam int NS = 4;
  localparam int TO = 15;

  logic              CLK = 1'b0;
  logic              reset_n;
  logic              cpu_req;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [2:0]        cpu_size;
  logic              cpu_wr;
  logic              cpu_ready;
  logic              cpu_done;
  logic [31:0]       cpu_rdata;
  logic              cpu_exc;
  logic [1:0]        cpu_cause;
  logic [NS-1:0]     s_sel;
  logic [31:0]       s_addr;
  logic              s_wr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic [32*NS-1:0]  s_rdata;
  logic [NS-1:0]     s_ack;

  int n_checks = 0;
  int n_errors = 0;

  logic          e_ready, e_done, e_exc, e_wr;
  logic [1:0]    e_cause;
  logic [31:0]   e_rdata, e_addr, e_wdata;
  logic [NS-1:0] e_sel;
  logic [3:0]    e_strb;

  logic [31:0]   cap_rdata, cap_wdata;
  logic [3:0]    cap_strb;
  logic [NS-1:0] cap_sel;
  logic          cap_wr;
  logic [1:0]    cap_cause;
  int            sel_cycles, cap_done_cyc, cap_exc_cyc, rel_cyc;

  always #5 CLK = ~CLK;

  mem_bus_ctrl #(.N_SLAVES(NS), .TIMEOUT(TO)) dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_size  (cpu_size),
    .cpu_wr    (cpu_wr),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .cpu_exc   (cpu_exc),
    .cpu_cause (cpu_cause),
    .s_sel     (s_sel),
    .s_addr    (s_addr),
    .s_wr      (s_wr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_rdata   (s_rdata),
    .s_ack     (s_ack)
  );

  // ---------------- model ----------------
  function automatic int m_bytes(input logic [2:0] sz);
    case (sz[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [1:0] m_cause(input logic [31:0] a, input logic [2:0] sz);
    if (sz == 3'b011 || sz == 3'b110 || sz == 3'b111) return 2'd1;
    if ((a % m_bytes(sz)) != 0) return 2'd1;
    if (a[31:24] >= NS) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [2:0] sz);
    logic [31:0] v;
    int nb;
    nb = m_bytes(sz);
    v = rd >> (8 * a[1:0]);
    if (nb == 4) return v;
    v = v & ((32'h1 << (8 * nb)) - 32'h1);
    if (!sz[2] && v >= (32'h1 << (8 * nb - 1))) v = v - (32'h1 << (8 * nb));
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [31:0] a, input logic [2:0] sz);
    return 4'(((1 << m_bytes(sz)) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [2:0] sz);
    case (m_bytes(sz))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    e_ready = 1'b1; e_done = 1'b0; e_exc = 1'b0; e_cause = 2'd0;
    e_rdata = 32'h0; e_sel = '0;
  endtask

  // Compare the current cycle at the falling edge, then move to just after the next rising edge.
  task automatic step();
    @(negedge CLK);
    chk("cpu_ready", 32'(cpu_ready), 32'(e_ready));
    chk("cpu_done",  32'(cpu_done),  32'(e_done));
    chk("cpu_exc",   32'(cpu_exc),   32'(e_exc));
    chk("cpu_cause", 32'(cpu_cause), 32'(e_cause));
    chk("cpu_rdata", cpu_rdata, e_rdata);
    chk("s_sel",     32'(s_sel),     32'(e_sel));
    if (e_sel != '0) begin
      chk("s_addr",  s_addr, e_addr);
      chk("s_wr",    32'(s_wr), 32'(e_wr));
      chk("s_wdata", s_wdata, e_wdata);
      chk("s_wstrb", 32'(s_wstrb), 32'(e_strb));
    end
    if (cpu_done) begin cap_rdata = cpu_rdata; cap_done_cyc = rel_cyc; end
    if (cpu_exc)  begin cap_cause = cpu_cause; cap_exc_cyc = rel_cyc; end
    if (s_sel != '0) begin
      cap_sel = s_sel; cap_wdata = s_wdata; cap_strb = s_wstrb; cap_wr = s_wr;
      sel_cycles++;
    end
    rel_cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sz,
                        input logic wr, input int ack_at, input logic [31:0] rd,
                        input logic [NS-1:0] stray);
    logic [1:0]    cause;
    logic [NS-1:0] sel;
    logic          acked;
    cause = m_cause(a, sz);
    acked = 1'b0;
    for (int k = 0; k < NS; k++)
      s_rdata[32*k +: 32] = (k == int'(a[31:24])) ? rd : (32'hBAD0_0000 | 32'(k));
    cap_rdata = 32'h5A5A_5A5A; cap_cause = 2'd0; cap_sel = '0; cap_wdata = 32'h0;
    cap_strb = 4'h0; cap_wr = 1'b0; sel_cycles = 0; cap_done_cyc = -1; cap_exc_cyc = -1;
    rel_cyc = 0;
    cpu_req = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_size = sz; cpu_wr = wr; s_ack = stray;
    set_idle();
    step();
    // Scrambled inputs while busy must be ignored.
    cpu_addr = ~a; cpu_wdata = ~wd; cpu_size = ~sz; cpu_wr = ~wr;
    if (cause != 2'd0) begin
      cpu_req = 1'b0;
      e_ready = 1'b0; e_exc = 1'b1; e_cause = cause;
      step();
    end else begin
      sel = NS'(1) << a[31:24];
      e_ready = 1'b0; e_sel = sel; e_addr = a; e_wr = wr;
      e_wdata = m_wdata(wd, sz); e_strb = wr ? m_strb(a, sz) : 4'h0;
      for (int c = 1; c <= TO; c++) begin
        s_ack = stray | ((c == ack_at) ? sel : '0);
        step();
        if (c == ack_at) begin
          acked = 1'b1;
          break;
        end
      end
      cpu_req = 1'b0; s_ack = stray; e_sel = '0;
      if (acked) begin
        e_done = 1'b1; e_rdata = wr ? 32'h0 : m_load(rd, a, sz);
      end else begin
        e_exc = 1'b1; e_cause = 2'd3;
      end
      step();
    end
    s_ack = '0; cpu_req = 1'b0;
    set_idle();
    $display("txn addr=%08h size=%b wr=%0d ack_at=%0d -> rdata=%08h cause=%0d sel_cycles=%0d",
             a, sz, wr, ack_at, cap_rdata, cap_cause, sel_cycles);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; cpu_req = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_size = 3'b0;
    cpu_wr = 1'b0; s_ack = '0; s_rdata = '0;
    e_addr = 32'h0; e_wdata = 32'h0; e_wr = 1'b0; e_strb = 4'h0;
    set_idle();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    chk("rst_done",  32'(cpu_done),  32'd0);
    chk("rst_exc",   32'(cpu_exc),   32'd0);
    chk("rst_cause", 32'(cpu_cause), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_sel",   32'(s_sel), 32'd0);
    chk("rst_addr",  s_addr, 32'h0);
    chk("rst_wr",    32'(s_wr), 32'd0);
    chk("rst_wdata", s_wdata, 32'h0);
    chk("rst_wstrb", 32'(s_wstrb), 32'd0);
    reset_n = 1'b1;
    @(posedge CLK);
    #1;

    access(32'h0100_0004, 32'h0, 3'b010, 1'b0, 1, 32'hDEAD_BEEF, 4'b0000);
    chk("lw_rdata", cap_rdata, 32'hDEAD_BEEF);
    chk("lw_done_cycle", 32'(cap_done_cyc), 32'd2);

    access(32'h0100_0003, 32'h0, 3'b000, 1'b0, 2, 32'h80FF_FF01, 4'b0000);
    chk("lb_rdata", cap_rdata, 32'hFFFF_FF80);
    access(32'h0100_0003, 32'h0, 3'b100, 1'b0, 3, 32'h80FF_FF01, 4'b0100);
    chk("lbu_rdata", cap_rdata, 32'h0000_0080);
    access(32'h0100_0002, 32'h0, 3'b101, 1'b0, 1, 32'h80FF_FF01, 4'b0000);
    chk("lhu_rdata", cap_rdata, 32'h0000_80FF);
    access(32'h0100_0002, 32'h0, 3'b001, 1'b0, 2, 32'h80FF_FF01, 4'b1000);
    chk("lh_rdata", cap_rdata, 32'hFFFF_80FF);

    access(32'h0200_0002, 32'h1234_ABCD, 3'b001, 1'b1, 1, 32'hFFFF_FFFF, 4'b0000);
    chk("sh_wstrb", 32'(cap_strb), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_sel",   32'(cap_sel), 32'h4);
    chk("sh_wr",    32'(cap_wr), 32'd1);
    chk("sh_rdata", cap_rdata, 32'h0);
    access(32'h0000_0001, 32'h0000_00A7, 3'b000, 1'b1, 2, 32'h0, 4'b0000);
    chk("sb_wstrb", 32'(cap_strb), 32'h2);
    chk("sb_wdata", cap_wdata, 32'hA7A7_A7A7);
    access(32'h0200_0003, 32'h0000_005C, 3'b100, 1'b1, 1, 32'h0, 4'b0000);
    chk("sbu_wstrb", 32'(cap_strb), 32'h8);
    access(32'h0300_0000, 32'h1122_3344, 3'b010, 1'b1, 4, 32'h0, 4'b0001);
    chk("sw_wdata", cap_wdata, 32'h1122_3344);

    access(32'h0000_0002, 32'h0, 3'b010, 1'b0, 1, 32'h0, 4'b0000);
    chk("mis_cause", 32'(cap_cause), 32'd1);
    chk("mis_exc_cycle", 32'(cap_exc_cyc), 32'd1);
    chk("mis_sel_cycles", 32'(sel_cycles), 32'd0);
    access(32'h0500_0000, 32'h0, 3'b010, 1'b0, 1, 32'h0, 4'b0000);
    chk("dec_cause", 32'(cap_cause), 32'd2);
    access(32'h0100_0001, 32'h0, 3'b001, 1'b0, 1, 32'h0, 4'b0000);
    chk("lh_odd_cause", 32'(cap_cause), 32'd1);
    access(32'h0100_0000, 32'h0, 3'b011, 1'b0, 1, 32'h0, 4'b0000);
    access(32'h0100_0000, 32'h0, 3'b110, 1'b1, 1, 32'h0, 4'b0000);
    chk("st110_cause", 32'(cap_cause), 32'd1);

    access(32'h0300_0000, 32'h0, 3'b010, 1'b0, 0, 32'h0, 4'b0001);
    chk("to_sel_cycles", 32'(sel_cycles), 32'd15);
    chk("to_cause", 32'(cap_cause), 32'd3);
    chk("to_exc_cycle", 32'(cap_exc_cyc), 32'd16);
    access(32'h0200_0008, 32'h0, 3'b010, 1'b0, TO, 32'h0BAD_F00D, 4'b0000);
    chk("ack_at_limit", cap_rdata, 32'h0BAD_F00D);

    // Reset pulse in the middle of a wait.
    s_rdata = '0;
    cpu_req = 1'b1; cpu_addr = 32'h0300_0000; cpu_wdata = 32'h0; cpu_size = 3'b010;
    cpu_wr = 1'b0; rel_cyc = 0;
    set_idle();
    step();
    cpu_req = 1'b0;
    e_ready = 1'b0; e_sel = 4'b1000; e_addr = 32'h0300_0000; e_wr = 1'b0;
    e_wdata = 32'h0; e_strb = 4'h0;
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_sel",   32'(s_sel), 32'd0);
    chk("rst_mid_ready", 32'(cpu_ready), 32'd1);
    #1 reset_n = 1'b1;
    @(posedge CLK);
    #1;
    $display("txn reset pulse during wait on addr=03000000");
    set_idle();
    access(32'h0100_0004, 32'h0, 3'b010, 1'b0, 2, 32'hCAFE_0123, 4'b0000);
    chk("post_rst_rdata", cap_rdata, 32'hCAFE_0123);

    set_idle();
    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
